// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode classes
// (the same values the ID-stage Control decoder uses) and the FSM encoding.
package hazard_ctrl_pkg;

  localparam logic [6:0] RTYPE       = 7'b0110011;
  localparam logic [6:0] I_TYPE_ALU  = 7'b0010011;
  localparam logic [6:0] I_TYPE_LW   = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] SB_TYPE     = 7'b1100011;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  // True when the opcode reads its rs1 field.
  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == RTYPE) || (op == I_TYPE_ALU) || (op == I_TYPE_LW) ||
           (op == S_TYPE) || (op == SB_TYPE);
  endfunction

  // True when the opcode reads its rs2 field.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == RTYPE) || (op == S_TYPE) || (op == SB_TYPE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Count enabled events, stopping at the maximum value.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles,
// ID-resolved branch flushes and data-cache miss freezes, plus event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        ifid_op_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              branch_taken_i,
  input  logic              dcache_stall_i,
  output logic              noop_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              pipe_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  state_t state;
  logic   load_use;
  logic   bubble_inc;
  logic   flush_inc;
  logic   miss_inc;

  // A load in EX whose destination feeds a source read in ID; x0 is never a hazard.
  assign load_use = idex_memread_i && (idex_rd_i != '0) &&
                    ((uses_rs1(ifid_op_i) && (idex_rd_i == ifid_rs1_i)) ||
                     (uses_rs2(ifid_op_i) && (idex_rd_i == ifid_rs2_i)));

  // Event qualifiers mirror the output priority: freeze beats bubble beats flush.
  assign bubble_inc = !dcache_stall_i && load_use;
  assign flush_inc  = !dcache_stall_i && !load_use && branch_taken_i;
  assign miss_inc   = (state == RUN) && dcache_stall_i;

  // Miss tracking FSM: one miss episode spans RUN -> MEMWAIT -> RUN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (dcache_stall_i)  state <= MEMWAIT;
        MEMWAIT: if (!dcache_stall_i) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Zero-latency control outputs; reset holds the pipeline clear.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    noop_o       = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    pipe_stall_o = 1'b0;
    if (!rst_i) begin
      noop_o       = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b1;
    end else if (dcache_stall_i) begin
      pipe_stall_o = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (load_use) begin
      noop_o       = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (miss_inc),
    .cnt_o (miss_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-bit counter build so saturation
// is reachable in a handful of cycles.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W  = 4;
  localparam int REG_AW = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [6:0]        ifid_op_i;
  logic [REG_AW-1:0] ifid_rs1_i;
  logic [REG_AW-1:0] ifid_rs2_i;
  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rd_i;
  logic              branch_taken_i;
  logic              dcache_stall_i;
  logic              noop_o;
  logic              pc_write_o;
  logic              ifid_write_o;
  logic              ifid_flush_o;
  logic              pipe_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  int checks = 0;
  int errors = 0;

  // Control vector order: {noop, pc_write, ifid_write, ifid_flush, pipe_stall}
  localparam logic [4:0] C_RESET  = 5'b10010;
  localparam logic [4:0] C_NORMAL = 5'b01100;
  localparam logic [4:0] C_BUBBLE = 5'b10000;
  localparam logic [4:0] C_FLUSH  = 5'b01110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ifid_op_i      (ifid_op_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .branch_taken_i (branch_taken_i),
    .dcache_stall_i (dcache_stall_i),
    .noop_o         (noop_o),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .pipe_stall_o   (pipe_stall_o),
    .bubble_cnt_o   (bubble_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {27'd0, noop_o, pc_write_o, ifid_write_o, ifid_flush_o, pipe_stall_o},
          {27'd0, exp});
  endtask

  task automatic check_cnt(input string tag, input int b, input int f, input int m);
    check({tag, "_bubble"}, {28'd0, bubble_cnt_o}, b);
    check({tag, "_flush"},  {28'd0, flush_cnt_o},  f);
    check({tag, "_miss"},   {28'd0, miss_cnt_o},   m);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i          = 1'b0;
    ifid_op_i      = 7'b0;
    ifid_rs1_i     = '0;
    ifid_rs2_i     = '0;
    idex_memread_i = 1'b0;
    idex_rd_i      = '0;
    branch_taken_i = 1'b0;
    dcache_stall_i = 1'b0;

    #2;
    check_ctrl("reset_ctrl", C_RESET);
    check_cnt("reset", 0, 0, 0);
    step();
    rst_i = 1'b1;
    check_ctrl("idle", C_NORMAL);

    // Load-use through rs2 of an R-type
    idex_memread_i = 1'b1; idex_rd_i = 5'd5;
    ifid_op_i = RTYPE; ifid_rs1_i = 5'd0; ifid_rs2_i = 5'd5;
    check_ctrl("lu_rs2", C_BUBBLE);
    step();
    idex_memread_i = 1'b0;
    check_ctrl("lu_after", C_NORMAL);
    check_cnt("lu", 1, 0, 0);

    // I-type ignores rs2; x0 destination never stalls; JAL-like opcode reads nothing
    idex_memread_i = 1'b1; idex_rd_i = 5'd5;
    ifid_op_i = I_TYPE_ALU; ifid_rs2_i = 5'd5;
    check_ctrl("rs2_filter", C_NORMAL);
    idex_rd_i = 5'd0; ifid_op_i = RTYPE; ifid_rs1_i = 5'd0; ifid_rs2_i = 5'd0;
    check_ctrl("rd_x0", C_NORMAL);
    idex_rd_i = 5'd7; ifid_op_i = 7'b1101111; ifid_rs1_i = 5'd7;
    check_ctrl("no_src_op", C_NORMAL);
    ifid_op_i = S_TYPE; ifid_rs1_i = 5'd1; ifid_rs2_i = 5'd7;
    check_ctrl("lu_store_rs2", C_BUBBLE);
    ifid_op_i = I_TYPE_LW; ifid_rs1_i = 5'd7; ifid_rs2_i = 5'd0;
    check_ctrl("lu_load_rs1", C_BUBBLE);
    idex_memread_i = 1'b0;
    step();
    check_cnt("filter", 1, 0, 0);

    // Branch flush, then branch shadowed by load-use
    branch_taken_i = 1'b1;
    check_ctrl("branch", C_FLUSH);
    step();
    check_cnt("branch", 1, 1, 0);
    idex_memread_i = 1'b1; idex_rd_i = 5'd5;
    ifid_op_i = SB_TYPE; ifid_rs1_i = 5'd5; ifid_rs2_i = 5'd9;
    check_ctrl("branch_lu", C_BUBBLE);
    step();
    check_cnt("branch_lu", 2, 1, 0);

    // Cache miss freeze over pending load-use and branch
    dcache_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_ctrl($sformatf("freeze%0d", i), C_FREEZE);
      step();
    end
    check_cnt("freeze", 2, 1, 1);
    dcache_stall_i = 1'b0;
    check_ctrl("release_lu", C_BUBBLE);
    step();
    check_cnt("release", 3, 1, 1);
    idex_memread_i = 1'b0;
    branch_taken_i = 1'b0;

    // Back-to-back misses separated by one low cycle count twice
    dcache_stall_i = 1'b1; step();
    dcache_stall_i = 1'b0; step();
    dcache_stall_i = 1'b1; step();
    dcache_stall_i = 1'b0;
    check_cnt("b2b_miss", 3, 1, 3);
    step();

    // Flush counter saturates at 15
    branch_taken_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    branch_taken_i = 1'b0;
    check_cnt("saturate", 3, 15, 3);

    // Reset asserted mid-miss
    dcache_stall_i = 1'b1;
    step();
    check_cnt("pre_rst_miss", 3, 15, 4);
    rst_i = 1'b0;
    check_ctrl("rst_mid_miss", C_RESET);
    check_cnt("rst_mid_miss", 0, 0, 0);
    step();
    check_cnt("rst_held", 0, 0, 0);
    rst_i = 1'b1;
    check_ctrl("rst_release_freeze", C_FREEZE);
    step();
    check_cnt("rst_release", 0, 0, 1);
    step();
    check_cnt("rst_miss_hold", 0, 0, 1);
    dcache_stall_i = 1'b0;
    check_ctrl("final_idle", C_NORMAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
